// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : word_serializer
// Description : Accepts WIDTH-bit words over a valid/ready handshake and
//               emits them as 8-bit bytes, least-significant byte first.
//               Each byte is held until accepted; the final byte of each
//               word is flagged. Back-to-back words stream with no bubble.
// Ports       : clock, reset      - clock, synchronous active-high reset
//               word_in/valid     - input word and its valid strobe
//               word_ready        - serializer can take a word this cycle
//               byte_out/valid    - current byte (0 when not valid)
//               byte_ready        - consumer accepts the current byte
//               byte_last         - current byte is the last of its word
//               word_count        - fully emitted words, wraps mod 2^16
// Revision    : 1.0 - initial release
// ============================================================================
module word_serializer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             byte_last,
    output logic [15:0]      word_count
);

    localparam int NB   = WIDTH / 8;
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NB - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_sr;
    logic [WIDTH-1:0]  w_sr_nxt;
    logic [IDXW-1:0]   r_idx;
    logic [IDXW-1:0]   w_idx_nxt;
    logic [15:0]       r_word_count;

    logic              w_byte_valid;
    logic              w_byte_last;
    logic              w_byte_acc;
    logic              w_word_acc;
    logic              w_word_ready;

    // Outputs derived from registered state only; word_ready is the single
    // combinational path (from byte_ready and reset).
    assign w_byte_valid = (r_state == S_SHIFT);
    assign w_byte_last  = w_byte_valid && (r_idx == c_last_idx);
    assign w_byte_acc   = w_byte_valid && byte_ready;
    // A new word may enter exactly when the held word's last byte leaves.
    assign w_word_ready = !reset && ((r_state == S_IDLE) || (w_byte_acc && w_byte_last));
    assign w_word_acc   = word_valid && w_word_ready;

    assign word_ready = w_word_ready;
    assign byte_valid = w_byte_valid;
    assign byte_last  = w_byte_last;
    assign byte_out   = w_byte_valid ? r_sr[7:0] : 8'h00;
    assign word_count = r_word_count;

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_idx_nxt   = r_idx;
        if (w_word_acc) begin
            // Covers both the idle load and the load-on-last-byte overlap.
            w_state_nxt = S_SHIFT;
            w_sr_nxt    = word_in;
            w_idx_nxt   = '0;
        end else if (w_byte_acc) begin
            if (w_byte_last) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_sr_nxt  = r_sr >> 8;
                w_idx_nxt = r_idx + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_idx        <= '0;
            r_word_count <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_idx   <= w_idx_nxt;
            if (w_byte_acc && w_byte_last) begin
                r_word_count <= r_word_count + 16'h0001;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_serializer
// Description : Directed self-checking bench for word_serializer, covering a
//               32-bit instance and an 8-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_serializer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] word_in32    = '0;
    logic        word_valid32 = 1'b0;
    logic        word_ready32;
    logic [7:0]  byte_out32;
    logic        byte_valid32;
    logic        byte_ready32 = 1'b0;
    logic        byte_last32;
    logic [15:0] word_count32;

    logic [7:0]  word_in8    = '0;
    logic        word_valid8 = 1'b0;
    logic        word_ready8;
    logic [7:0]  byte_out8;
    logic        byte_valid8;
    logic        byte_ready8 = 1'b0;
    logic        byte_last8;
    logic [15:0] word_count8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    word_serializer #(.WIDTH(32)) u_dut32 (
        .clock      (clock),
        .reset      (reset),
        .word_in    (word_in32),
        .word_valid (word_valid32),
        .word_ready (word_ready32),
        .byte_out   (byte_out32),
        .byte_valid (byte_valid32),
        .byte_ready (byte_ready32),
        .byte_last  (byte_last32),
        .word_count (word_count32)
    );

    word_serializer #(.WIDTH(8)) u_dut8 (
        .clock      (clock),
        .reset      (reset),
        .word_in    (word_in8),
        .word_valid (word_valid8),
        .word_ready (word_ready8),
        .byte_out   (byte_out8),
        .byte_valid (byte_valid8),
        .byte_ready (byte_ready8),
        .byte_last  (byte_last8),
        .word_count (word_count8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_byte32(input string tag, input logic [7:0] b, input logic last);
        check({tag, "_valid"}, {31'd0, byte_valid32}, 32'd1);
        check({tag, "_byte"},  {24'd0, byte_out32}, {24'd0, b});
        check({tag, "_last"},  {31'd0, byte_last32}, {31'd0, last});
    endtask

    task automatic expect_idle32(input string tag, input logic [15:0] cnt);
        check({tag, "_valid"}, {31'd0, byte_valid32}, 32'd0);
        check({tag, "_byte"},  {24'd0, byte_out32}, 32'd0);
        check({tag, "_last"},  {31'd0, byte_last32}, 32'd0);
        check({tag, "_count"}, {16'd0, word_count32}, {16'd0, cnt});
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        word_valid32 = 1'b0;
        byte_ready32 = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    logic [7:0] exp_bytes [4];
    int         bad8;

    initial begin
        // ---------------- reset state ----------------
        step();
        step();
        #1;
        expect_idle32("rst", 16'h0000);
        check("rst_wready", {31'd0, word_ready32}, 32'd0);
        check("rst_wready8", {31'd0, word_ready8}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_wready", {31'd0, word_ready32}, 32'd1);

        // ---------------- single word, no stall ----------------
        word_in32    = 32'h44332211;
        word_valid32 = 1'b1;
        byte_ready32 = 1'b1;
        step();
        word_valid32 = 1'b0;
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            expect_byte32($sformatf("single_b%0d", i), exp_bytes[i], i == 3);
            if (i == 3) check("single_wready_last", {31'd0, word_ready32}, 32'd1);
            else        check("single_wready_mid", {31'd0, word_ready32}, 32'd0);
            if (i == 0) check("single_count0", {16'd0, word_count32}, 32'd0);
            step();
        end
        expect_idle32("single_end", 16'h0001);
        check("single_end_wready", {31'd0, word_ready32}, 32'd1);

        // ---------------- stall ----------------
        do_reset();
        word_in32    = 32'h44332211;
        word_valid32 = 1'b1;
        byte_ready32 = 1'b1;
        step();
        word_valid32 = 1'b0;
        expect_byte32("stall_b0", 8'h11, 1'b0);
        step();
        byte_ready32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_byte32($sformatf("stall_hold%0d", i), 8'h22, 1'b0);
            step();
        end
        byte_ready32 = 1'b1;
        expect_byte32("stall_hold3", 8'h22, 1'b0);
        step();
        expect_byte32("stall_b2", 8'h33, 1'b0);
        step();
        expect_byte32("stall_b3", 8'h44, 1'b1);
        step();
        expect_idle32("stall_end", 16'h0001);

        // ---------------- back-to-back ----------------
        do_reset();
        word_in32    = 32'hA3A2A1A0;
        word_valid32 = 1'b1;
        byte_ready32 = 1'b1;
        step();
        word_in32 = 32'hB3B2B1B0;
        exp_bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 4; i++) begin
            expect_byte32($sformatf("b2b_a%0d", i), exp_bytes[i], i == 3);
            if (i == 3) check("b2b_wready_a3", {31'd0, word_ready32}, 32'd1);
            step();
        end
        word_valid32 = 1'b0;
        exp_bytes = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        for (int i = 0; i < 4; i++) begin
            expect_byte32($sformatf("b2b_b%0d", i), exp_bytes[i], i == 3);
            step();
        end
        expect_idle32("b2b_end", 16'h0002);

        // ---------------- ready gating ----------------
        do_reset();
        word_in32    = 32'h04030201;
        word_valid32 = 1'b1;
        byte_ready32 = 1'b1;
        step();
        word_in32 = 32'hDEADBEEF;
        expect_byte32("gate_b0", 8'h01, 1'b0);
        step();
        byte_ready32 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("gate_wready_stall", {31'd0, word_ready32}, 32'd0);
            expect_byte32($sformatf("gate_hold%0d", i), 8'h02, 1'b0);
            step();
        end
        byte_ready32 = 1'b1;
        check("gate_wready_mid", {31'd0, word_ready32}, 32'd0);
        step();
        expect_byte32("gate_b2", 8'h03, 1'b0);
        step();
        expect_byte32("gate_b3", 8'h04, 1'b1);
        check("gate_wready_last", {31'd0, word_ready32}, 32'd1);
        step();
        word_valid32 = 1'b0;
        exp_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 4; i++) begin
            expect_byte32($sformatf("gate_new%0d", i), exp_bytes[i], i == 3);
            step();
        end
        expect_idle32("gate_end", 16'h0002);

        // ---------------- reset mid-word ----------------
        do_reset();
        word_in32    = 32'h0D0C0B0A;
        word_valid32 = 1'b1;
        byte_ready32 = 1'b1;
        step();
        word_valid32 = 1'b0;
        repeat (4) step();
        check("midrst_pre_count", {16'd0, word_count32}, 32'd1);
        word_in32    = 32'h44332211;
        word_valid32 = 1'b1;
        step();
        word_valid32 = 1'b0;
        expect_byte32("midrst_b0", 8'h11, 1'b0);
        step();
        expect_byte32("midrst_b1", 8'h22, 1'b0);
        step();
        reset = 1'b1;
        #1;
        check("midrst_wready_in_rst", {31'd0, word_ready32}, 32'd0);
        step();
        expect_idle32("midrst", 16'h0000);
        reset = 1'b0;
        #1;
        expect_idle32("midrst_after", 16'h0000);
        word_in32    = 32'h88776655;
        word_valid32 = 1'b1;
        step();
        word_valid32 = 1'b0;
        exp_bytes = '{8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 4; i++) begin
            expect_byte32($sformatf("midrst_new%0d", i), exp_bytes[i], i == 3);
            step();
        end
        expect_idle32("midrst_end", 16'h0001);

        // ---------------- narrow config and wrap ----------------
        do_reset();
        bad8        = 0;
        word_in8    = 8'h00;
        word_valid8 = 1'b1;
        byte_ready8 = 1'b1;
        step();
        for (int i = 1; i <= 65537; i++) begin
            logic [31:0] iv;
            logic [31:0] pv;
            iv = i;
            pv = i - 1;
            word_in8 = iv[7:0];
            if (i == 65537) word_valid8 = 1'b0;
            #1;
            if (byte_valid8 !== 1'b1 || byte_last8 !== 1'b1 || byte_out8 !== pv[7:0]) bad8++;
            if (i == 1)     check("w8_first_count", {16'd0, word_count8}, 32'd0);
            if (i == 65536) check("w8_count_ffff", {16'd0, word_count8}, 32'h0000FFFF);
            if (i == 65537) check("w8_count_wrap0", {16'd0, word_count8}, 32'd0);
            if (i == 2)     check("w8_wready", {31'd0, word_ready8}, 32'd1);
            step();
        end
        check("w8_bad_bytes", bad8, 32'd0);
        check("w8_end_valid", {31'd0, byte_valid8}, 32'd0);
        check("w8_end_last", {31'd0, byte_last8}, 32'd0);
        check("w8_end_count", {16'd0, word_count8}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
